sgd_dispatch_a_bcast_buffer: RTL and testbench

- Consumes the merged 512-bit A-stream produced by the HBM read/merge stage: `dispatch_axb_a_data` / `dispatch_axb_a_wr_en`.
- Returns `dispatch_axb_a_almost_full` as backpressure to that stage.
- Buffers the words in a synchronous FIFO and broadcasts each head word to NUM_ENGINES SGD engines.
- Each engine has its own valid/ready. A word is retired only after every engine has accepted it, in any order and on any cycle.

---
 rtl/sgd_dispatch_a_bcast_buffer_if.sv | 38 +++
 rtl/sgd_dispatch_a_bcast_buffer.sv | 119 +++++++++++
 tb/tb_sgd_dispatch_a_bcast_buffer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sgd_dispatch_a_bcast_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : sgd_dispatch_a_bcast_buffer_if
//  Description : Upstream write port and broadcast head bus of the A buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sgd_dispatch_a_bcast_buffer_if #(
    parameter int DATA_W      = 512,
    parameter int NUM_ENGINES = 8
);
    logic [DATA_W-1:0]      dispatch_axb_a_data;
    logic                   dispatch_axb_a_wr_en;
    logic                   dispatch_axb_a_almost_full;
    logic [DATA_W-1:0]      a_data_out;
    logic [NUM_ENGINES-1:0] a_valid;
    logic [NUM_ENGINES-1:0] a_ready;

    // Environment side: drives words in, takes them out per engine.
    modport master (
        output dispatch_axb_a_data,
        output dispatch_axb_a_wr_en,
        input  dispatch_axb_a_almost_full,
        input  a_data_out,
        input  a_valid,
        output a_ready
    );

    // Buffer side.
    modport slave (
        input  dispatch_axb_a_data,
        input  dispatch_axb_a_wr_en,
        output dispatch_axb_a_almost_full,
        output a_data_out,
        output a_valid,
        input  a_ready
    );
endinterface
`default_nettype wire

// File: rtl/sgd_dispatch_a_bcast_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : sgd_dispatch_a_bcast_buffer
//  Description : FWFT FIFO broadcasting each head word to NUM_ENGINES engines;
//                a word retires once every engine has taken it.
//  Revision    : 1.0 - initial release
// ============================================================================
module sgd_dispatch_a_bcast_buffer #(
    parameter int DATA_W      = 512,
    parameter int DEPTH       = 64,
    parameter int NUM_ENGINES = 8,
    parameter int AF_SLACK    = 8
) (
    input  wire logic                       user_clk,
    input  wire logic                       rst,
    sgd_dispatch_a_bcast_buffer_if.slave    bus,
    output logic [$clog2(DEPTH):0]          fill_count,
    output logic                            overflow
);

    localparam int c_addr_w = $clog2(DEPTH);
    localparam int c_cnt_w  = c_addr_w + 1;

    localparam logic [c_cnt_w-1:0]  c_depth     = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0]  c_af_thresh = c_cnt_w'(DEPTH - AF_SLACK);
    localparam logic [c_cnt_w-1:0]  c_cnt_one   = c_cnt_w'(1);
    localparam logic [c_addr_w-1:0] c_ptr_one   = c_addr_w'(1);

    logic [DATA_W-1:0]      r_mem [DEPTH];
    logic [c_addr_w-1:0]    r_wr_ptr;
    logic [c_addr_w-1:0]    r_rd_ptr;
    logic [c_cnt_w-1:0]     r_mem_count;
    logic [c_cnt_w-1:0]     r_fill_count;
    logic [DATA_W-1:0]      r_head;
    logic                   r_head_valid;
    logic [NUM_ENGINES-1:0] r_done;
    logic                   r_almost_full;
    logic                   r_overflow;

    logic                   w_full;
    logic                   w_wr_acc;
    logic [NUM_ENGINES-1:0] w_valid;
    logic [NUM_ENGINES-1:0] w_accept;
    logic                   w_pop;
    logic                   w_load;
    logic [c_cnt_w-1:0]     w_fill_next;
    logic [c_cnt_w-1:0]     w_mem_count_next;

    // fill_count counts the head register too, so "full" covers RAM plus head.
    assign w_full   = (r_fill_count == c_depth);
    assign w_wr_acc = bus.dispatch_axb_a_wr_en & ~w_full;

    assign w_valid  = {NUM_ENGINES{r_head_valid}} & ~r_done;
    assign w_accept = w_valid & bus.a_ready;
    assign w_pop    = r_head_valid & (&(r_done | w_accept));

    // Refill the head whenever it is empty or being retired this cycle.
    assign w_load   = (r_mem_count != '0) & (~r_head_valid | w_pop);

    assign w_fill_next      = r_fill_count + (w_wr_acc ? c_cnt_one : '0)
                                           - (w_pop    ? c_cnt_one : '0);
    assign w_mem_count_next = r_mem_count  + (w_wr_acc ? c_cnt_one : '0)
                                           - (w_load   ? c_cnt_one : '0);

    // Storage array carries no reset; stale contents are never exposed.
    always_ff @(posedge user_clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= bus.dispatch_axb_a_data;
        end
    end

    always_ff @(posedge user_clk) begin
        if (w_load) begin
            r_head <= r_mem[r_rd_ptr];
        end
    end

    always_ff @(posedge user_clk) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_mem_count   <= '0;
            r_fill_count  <= '0;
            r_head_valid  <= 1'b0;
            r_done        <= '0;
            r_almost_full <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_load) begin
                r_rd_ptr     <= r_rd_ptr + c_ptr_one;
                r_head_valid <= 1'b1;
            end else if (w_pop) begin
                r_head_valid <= 1'b0;
            end
            if (w_pop) begin
                r_done <= '0;
            end else begin
                r_done <= r_done | w_accept;
            end
            if (bus.dispatch_axb_a_wr_en & w_full) begin
                r_overflow <= 1'b1;
            end
            r_mem_count   <= w_mem_count_next;
            r_fill_count  <= w_fill_next;
            r_almost_full <= (w_fill_next >= c_af_thresh);
        end
    end

    assign bus.a_data_out                 = r_head;
    assign bus.a_valid                    = w_valid;
    assign bus.dispatch_axb_a_almost_full = r_almost_full;
    assign fill_count                     = r_fill_count;
    assign overflow                       = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_sgd_dispatch_a_bcast_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sgd_dispatch_a_bcast_buffer
//  Description : Table vectors, directed corner sequences and randomized
//                traffic against a queue-based model of the broadcast buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sgd_dispatch_a_bcast_buffer;

    localparam int DATA_W   = 512;
    localparam int DEPTH    = 64;
    localparam int NE       = 8;
    localparam int AF_SLACK = 8;
    localparam int CW       = $clog2(DEPTH) + 1;

    logic          user_clk = 1'b0;
    logic          rst;
    logic [CW-1:0] fill_count;
    logic          overflow;

    sgd_dispatch_a_bcast_buffer_if #(.DATA_W(DATA_W), .NUM_ENGINES(NE)) bus ();

    sgd_dispatch_a_bcast_buffer #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_ENGINES(NE), .AF_SLACK(AF_SLACK)
    ) u_dut (
        .user_clk   (user_clk),
        .rst        (rst),
        .bus        (bus.slave),
        .fill_count (fill_count),
        .overflow   (overflow)
    );

    always #5 user_clk = ~user_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: words held in write order, each tagged with the edge that wrote it.
    typedef struct {
        logic [DATA_W-1:0] d;
        int unsigned       c;
    } ent_t;
    ent_t          mq[$];
    logic [NE-1:0] m_done;
    bit            m_ovf;
    bit            m_af;
    int unsigned   m_cyc = 0;

    task automatic chk(string name, logic [DATA_W-1:0] act, logic [DATA_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // A front word is offered once at least one edge has passed since its write.
    function automatic bit m_vis();
        return (mq.size() > 0) && (mq[0].c < m_cyc);
    endfunction

    function automatic logic [NE-1:0] m_valid();
        return m_vis() ? ~m_done : '0;
    endfunction

    task automatic m_edge(bit wr, logic [DATA_W-1:0] d, logic [NE-1:0] rdy);
        logic [NE-1:0] acc;
        bit            pop;
        bit            full;
        acc  = m_valid() & rdy;
        pop  = m_vis() && ((m_done | acc) == '1);
        full = (mq.size() == DEPTH);
        m_cyc++;
        if (pop) begin
            mq.delete(0);
            m_done = '0;
        end else begin
            m_done = m_done | acc;
        end
        if (wr) begin
            if (full) m_ovf = 1'b1;
            else      mq.push_back('{d, m_cyc});
        end
        m_af = (mq.size() >= DEPTH - AF_SLACK);
    endtask

    task automatic compare_all(string tag);
        logic [NE-1:0] ev;
        ev = m_valid();
        chk({tag, "_valid"}, bus.a_valid, ev);
        chk({tag, "_fill"}, fill_count, mq.size());
        chk({tag, "_af"}, bus.dispatch_axb_a_almost_full, m_af);
        chk({tag, "_ovf"}, overflow, m_ovf);
        if (ev != '0) chk({tag, "_data"}, bus.a_data_out, mq[0].d);
    endtask

    task automatic step(bit wr, logic [DATA_W-1:0] d, logic [NE-1:0] rdy, string tag);
        bus.dispatch_axb_a_wr_en = wr;
        bus.dispatch_axb_a_data  = d;
        bus.a_ready              = rdy;
        @(posedge user_clk);
        m_edge(wr, d, rdy);
        #1;
        compare_all(tag);
    endtask

    task automatic do_reset(string tag);
        rst                      = 1'b1;
        bus.dispatch_axb_a_wr_en = 1'b0;
        bus.a_ready              = '0;
        @(posedge user_clk);
        m_cyc++;
        mq.delete();
        m_done = '0;
        m_ovf  = 1'b0;
        m_af   = 1'b0;
        #1;
        rst = 1'b0;
        compare_all(tag);
    endtask

    typedef struct {
        bit            wr;
        logic [7:0]    wbyte;
        logic [NE-1:0] rdy;
        logic [NE-1:0] exp_valid;
        int            exp_fill;
        logic [7:0]    head_byte;
    } vec_t;

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : main
        vec_t              tbl[8];
        logic [DATA_W-1:0] exp_w;
        int                got;
        bit                saw_af;
        bit [4:0]          af_hist;
        bit                wr;

        // Single word with all ready, then staggered acceptance of one word.
        tbl[0] = '{1'b1, 8'hA5, 8'h00, 8'h00, 1, 8'h00};
        tbl[1] = '{1'b0, 8'h00, 8'hFF, 8'hFF, 1, 8'hA5};
        tbl[2] = '{1'b0, 8'h00, 8'hFF, 8'h00, 0, 8'h00};
        tbl[3] = '{1'b1, 8'h3C, 8'hFF, 8'h00, 1, 8'h00};
        tbl[4] = '{1'b0, 8'h00, 8'h00, 8'hFF, 1, 8'h3C};
        tbl[5] = '{1'b0, 8'h00, 8'h01, 8'hFE, 1, 8'h3C};
        tbl[6] = '{1'b0, 8'h00, 8'h7E, 8'h80, 1, 8'h3C};
        tbl[7] = '{1'b0, 8'h00, 8'h80, 8'h00, 0, 8'h00};

        rst                      = 1'b1;
        bus.dispatch_axb_a_wr_en = 1'b0;
        bus.dispatch_axb_a_data  = '0;
        bus.a_ready              = '0;
        repeat (2) @(posedge user_clk);
        do_reset("reset");

        for (int i = 0; i < 8; i++) begin
            step(tbl[i].wr, {64{tbl[i].wbyte}}, tbl[i].rdy, "tbl");
            chk("tbl_vec_valid", bus.a_valid, tbl[i].exp_valid);
            chk("tbl_vec_fill", fill_count, tbl[i].exp_fill);
            if (tbl[i].exp_valid != '0)
                chk("tbl_vec_data", bus.a_data_out, {64{tbl[i].head_byte}});
        end

        // Streaming 200 words through the pointer wrap.
        do_reset("rst_stream");
        got    = 0;
        saw_af = 1'b0;
        for (int i = 0; i < 206; i++) begin
            if (bus.a_valid == '1) begin
                exp_w = DATA_W'(got);
                chk("stream_order", bus.a_data_out, exp_w);
                got++;
            end
            step(i < 200, DATA_W'(i), '1, "stream");
            if (bus.dispatch_axb_a_almost_full) saw_af = 1'b1;
        end
        chk("stream_count", got, 200);
        chk("stream_no_af", saw_af, 1'b0);

        // Almost-full threshold rise and fall.
        do_reset("rst_thr");
        for (int i = 0; i < 56; i++) begin
            step(1'b1, DATA_W'(i), '0, "thr_fill");
            if (i == 54) chk("thr_af_low_55", bus.dispatch_axb_a_almost_full, 1'b0);
        end
        chk("thr_af_high_56", bus.dispatch_axb_a_almost_full, 1'b1);
        for (int i = 0; i < 80 && fill_count != 0; i++) begin
            step(1'b0, '0, '1, "thr_drain");
            if (fill_count == 55) chk("thr_af_fall_55", bus.dispatch_axb_a_almost_full, 1'b0);
        end
        chk("thr_drained", fill_count, 0);

        // Overflow: 66 writes into a stalled buffer.
        do_reset("rst_ovf");
        for (int i = 0; i < 66; i++) begin
            step(1'b1, DATA_W'(i), '0, "ovf_fill");
            if (i == 63) chk("ovf_clear_at_64", overflow, 1'b0);
            if (i == 64) chk("ovf_set_at_65", overflow, 1'b1);
        end
        chk("ovf_fill64", fill_count, 64);
        chk("ovf_sticky", overflow, 1'b1);
        got = 0;
        for (int i = 0; i < 100 && (fill_count != 0 || bus.a_valid != '0); i++) begin
            if (bus.a_valid == '1) begin
                exp_w = DATA_W'(got);
                chk("ovf_drain_order", bus.a_data_out, exp_w);
                got++;
            end
            step(1'b0, '0, '1, "ovf_drain");
        end
        chk("ovf_drain_count", got, 64);

        // Reset with a half-accepted head and nine words queued behind it.
        do_reset("rst_mid0");
        for (int i = 0; i < 10; i++) step(1'b1, DATA_W'(i + 100), '0, "mid_fill");
        step(1'b0, '0, 8'h0F, "mid_half");
        chk("mid_half_valid", bus.a_valid, 8'hF0);
        do_reset("rst_mid");
        chk("mid_valid0", bus.a_valid, 8'h00);
        chk("mid_fill0", fill_count, 0);
        chk("mid_af0", bus.dispatch_axb_a_almost_full, 1'b0);
        step(1'b1, {16{32'hDEADBEEF}}, '0, "mid_wr");
        step(1'b0, '0, '0, "mid_wait");
        chk("mid_new_valid", bus.a_valid, 8'hFF);
        chk("mid_new_data", bus.a_data_out, {16{32'hDEADBEEF}});

        // Random traffic; upstream honours almost_full with a 5-cycle lag.
        do_reset("rst_rand");
        af_hist = '0;
        for (int i = 0; i < 1500; i++) begin
            wr = ($urandom_range(0, 3) != 0) && !af_hist[4];
            step(wr, {16{$urandom}}, NE'($urandom) & NE'($urandom), "rand_honour");
            af_hist = {af_hist[3:0], bus.dispatch_axb_a_almost_full};
        end
        chk("rand_no_ovf", overflow, 1'b0);
        for (int i = 0; i < 1500; i++) begin
            wr = ($urandom_range(0, 3) != 0);
            step(wr, {16{$urandom}}, NE'($urandom) & NE'($urandom) & NE'($urandom),
                 "rand_free");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
